// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-cipher core and its key sequencer:
// byte-array types, S-boxes, round constants and GF(2^8) helpers.
package aes_pkg;

  // Byte 0 is the leftmost (most significant) byte, i.e. FIPS-197 in0.
  typedef logic [0:15][7:0] block_t;
  typedef logic [0:3][7:0]  word_t;

  typedef enum logic [1:0] {IDLE, KEXP, DEC} fsm_t;

  localparam logic [3:0] ROUND_END  = 4'd11;
  localparam logic [3:0] KEXP_STEPS = 4'd10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] INV_MIX_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic word_t sub_rot_word(input word_t w);
    return {SBOX[w[1]], SBOX[w[2]], SBOX[w[3]], SBOX[w[0]]};
  endfunction

endpackage

// File: rtl/aes_inv_keys.sv
// Round-key register for the inverse core: walks the schedule forward to rk10,
// then backward one key per round. Optional rk10 cache under AES_INV_KEY_CACHE_EN.
module aes_inv_keys
  import aes_pkg::*;
(
  input  logic       sclk,
  input  logic       srst,
  input  logic       load,
  input  logic       fwd_step,
  input  logic       bwd_step,
  input  logic [3:0] rc_idx,
  input  block_t     key,
  output block_t     rk,
  output logic       hit
);

  word_t      w  [4];
  word_t      fw [4];
  word_t      bw [4];
  block_t     rk_fwd;
  block_t     rk_bwd;
  block_t     rk_load;
  logic [7:0] rc;

`ifdef AES_INV_KEY_CACHE_EN
  block_t cache_key;
  block_t cache_rk10;
  logic   cache_valid;

  assign hit     = cache_valid && (key == cache_key);
  assign rk_load = hit ? cache_rk10 : key;

  always_ff @(posedge sclk) begin
    if (srst)
      cache_valid <= 1'b0;
    else if (load && !hit)
      cache_valid <= 1'b0;
    else if (fwd_step && rc_idx == KEXP_STEPS)
      cache_valid <= 1'b1;
  end

  // NOTE: the cached key/rk10 need no reset; they are only used while cache_valid=1.
  always_ff @(posedge sclk) begin
    if (load && !hit)
      cache_key <= key;
    if (fwd_step && rc_idx == KEXP_STEPS)
      cache_rk10 <= rk_fwd;
  end
`else
  assign hit     = 1'b0;
  assign rk_load = key;
`endif

  // NOTE: always_comb uses blocking '=' and gives every output a value on every path, so no latch.
  always_comb begin
    rc = (rc_idx >= 4'd1 && rc_idx <= 4'd10) ? RCON[rc_idx] : 8'h00;
    for (int c = 0; c < 4; c++)
      for (int b = 0; b < 4; b++)
        w[c][b] = rk[4*c + b];

    fw[0] = w[0] ^ sub_rot_word(w[3]) ^ {rc, 24'h000000};
    fw[1] = w[1] ^ fw[0];
    fw[2] = w[2] ^ fw[1];
    fw[3] = w[3] ^ fw[2];

    // Undo the forward chain: recover w3..w1 first, then w0 from the recovered w3.
    bw[3] = w[3] ^ w[2];
    bw[2] = w[2] ^ w[1];
    bw[1] = w[1] ^ w[0];
    bw[0] = w[0] ^ sub_rot_word(bw[3]) ^ {rc, 24'h000000};

    for (int c = 0; c < 4; c++)
      for (int b = 0; b < 4; b++) begin
        rk_fwd[4*c + b] = fw[c][b];
        rk_bwd[4*c + b] = bw[c][b];
      end
  end

  always_ff @(posedge sclk) begin
    if (srst)
      rk <= '0;
    else if (load)
      rk <= rk_load;
    else if (fwd_step)
      rk <= rk_fwd;
    else if (bwd_step)
      rk <= rk_bwd;
  end

endmodule

// File: rtl/aes_inv_core.sv
// Iterative AES-128 inverse cipher: KEXP to rk10, then one inverse round per clock.
// AES_INV_KEY_CACHE_EN enables the rk10 cache inside aes_inv_keys (skips KEXP on a key hit).
module aes_inv_core
  import aes_pkg::*;
(
  input  logic   sclk,
  input  logic   srst,
  input  logic   en,
  input  block_t text,
  input  block_t key,
  output logic   busy,
  output logic   valid,
  output block_t val
);

  fsm_t       fsm;
  logic [3:0] cnt;
  block_t     rk;
  logic       hit;
  logic       load;
  logic       fwd_step;
  logic       bwd_step;
  logic [3:0] rc_idx;
  block_t     sr;
  block_t     ark;
  block_t     mix;

  assign load     = (fsm == IDLE) && en;
  assign fwd_step = (fsm == KEXP);
  assign bwd_step = (fsm == DEC) && (cnt < ROUND_END);
  // Forward step i produces rk[i+1]; backward step at DEC step d produces rk[10-d].
  assign rc_idx   = (fsm == KEXP) ? cnt + 4'd1 : ROUND_END - cnt;

  aes_inv_keys u_keys (
    .sclk     (sclk),
    .srst     (srst),
    .load     (load),
    .fwd_step (fwd_step),
    .bwd_step (bwd_step),
    .rc_idx   (rc_idx),
    .key      (key),
    .rk       (rk),
    .hit      (hit)
  );

  always_comb begin
    mix = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[r + 4*c] = val[r + 4*((c - r + 4) % 4)];
    for (int i = 0; i < 16; i++)
      ark[i] = INV_SBOX[sr[i]] ^ rk[i];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          mix[r + 4*c] = mix[r + 4*c] ^ gmul(ark[4*c + k], INV_MIX_COEF[(k - r + 4) % 4]);
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      fsm   <= IDLE;
      cnt   <= 4'd0;
      val   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (en) begin
            val  <= text;
            busy <= 1'b1;
            cnt  <= hit ? 4'd1 : 4'd0;
            fsm  <= hit ? DEC : KEXP;
          end
        end
        KEXP: begin
          if (cnt == KEXP_STEPS - 4'd1) begin
            cnt <= 4'd1;
            fsm <= DEC;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DEC: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd1) begin
            val <= val ^ rk;
          end else if (cnt == ROUND_END) begin
            val   <= ark;
            cnt   <= 4'd0;
            fsm   <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b1;
          end else begin
            val <= mix;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_core.sv
// Directed bench for aes_inv_core with an expected-plaintext/latency scoreboard.
// Latency expectations follow AES_INV_KEY_CACHE_EN when it is defined.
module tb_aes_inv_core;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

`ifdef AES_INV_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic         sclk = 1'b0;
  logic         srst;
  logic         en;
  logic [127:0] text;
  logic [127:0] key;
  logic         busy;
  logic         valid;
  logic [127:0] val;

  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q [$];
  int           lat_q [$];
  logic [127:0] m_key;
  bit           m_cv = 1'b0;

  aes_inv_core dut (
    .sclk  (sclk),
    .srst  (srst),
    .en    (en),
    .text  (text),
    .key   (key),
    .busy  (busy),
    .valid (valid),
    .val   (val)
  );

  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; en is sampled on the next edge (E0).
  task automatic send(input logic [127:0] t, input logic [127:0] k, input logic [127:0] p);
    int lat;
    lat = (CACHE_EN && m_cv && k === m_key) ? 11 : 21;
    if (lat == 21) begin
      m_key = k;
      m_cv  = 1'b1;
    end
    exp_q.push_back(p);
    lat_q.push_back(lat);
    en   = 1'b1;
    text = t;
    key  = k;
    @(posedge sclk);
    #1;
    en = 1'b0;
    check("busy_after_accept", {127'd0, busy}, 128'd1);
  endtask

  task automatic wait_valid(input string tag, input int start);
    int           lat;
    int           exp_lat;
    logic [127:0] exp_pt;
    lat = start;
    while (valid !== 1'b1 && lat < 40) begin
      @(posedge sclk);
      #1;
      lat++;
    end
    check({tag, "_valid"}, {127'd0, valid}, 128'd1);
    check({tag, "_sb_nonempty"}, 128'(exp_q.size() != 0), 128'd1);
    if (exp_q.size() != 0) begin
      exp_pt  = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
      check({tag, "_val"}, val, exp_pt);
      check({tag, "_busy_low"}, {127'd0, busy}, 128'd0);
    end
  endtask

  task automatic quiet_watch(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge sclk);
      #1;
      if (valid === 1'b1) pulses++;
    end
    check({tag, "_no_valid"}, 128'(pulses), 128'd0);
    check({tag, "_idle"}, {127'd0, busy}, 128'd0);
  endtask

  initial begin
    srst = 1'b1;
    en   = 1'b0;
    text = '0;
    key  = '0;
    repeat (3) @(posedge sclk);
    #1;
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_valid", {127'd0, valid}, 128'd0);
    check("reset_val", val, 128'd0);
    srst = 1'b0;
    @(posedge sclk);
    #1;

    // FIPS-197 C.1, then the one-cycle pulse and held result
    send(C1_CT, C1_KEY, C1_PT);
    wait_valid("c1", 0);
    @(posedge sclk);
    #1;
    check("c1_pulse_end", {127'd0, valid}, 128'd0);
    check("c1_val_hold", val, C1_PT);

    // FIPS-197 Appendix B
    send(B_CT, B_KEY, B_PT);
    wait_valid("appb", 0);

    // en with a different block at E5 must be ignored
    send(C1_CT, C1_KEY, C1_PT);
    repeat (4) begin
      @(posedge sclk);
      #1;
    end
    en   = 1'b1;
    text = B_CT;
    key  = B_KEY;
    @(posedge sclk);
    #1;
    en = 1'b0;
    check("ignore_busy", {127'd0, busy}, 128'd1);
    wait_valid("ignore", 5);
    quiet_watch("ignore_after", 25);

    // srst at E15 aborts the block
    send(B_CT, B_KEY, B_PT);
    repeat (14) begin
      @(posedge sclk);
      #1;
    end
    srst = 1'b1;
    @(posedge sclk);
    #1;
    srst = 1'b0;
    m_cv = 1'b0;
    exp_q.delete();
    lat_q.delete();
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_valid", {127'd0, valid}, 128'd0);
    check("abort_val", val, 128'd0);
    quiet_watch("abort_after", 25);

    // Recovery, then back-to-back with en in the valid cycle
    send(C1_CT, C1_KEY, C1_PT);
    wait_valid("recover", 0);
    send(B_CT, B_KEY, B_PT);
    wait_valid("b2b", 0);

    // Same key twice, then a new key
    @(posedge sclk);
    #1;
    send(C1_CT, C1_KEY, C1_PT);
    wait_valid("key_first", 0);
    @(posedge sclk);
    #1;
    send(C1_CT, C1_KEY, C1_PT);
    wait_valid("key_repeat", 0);
    @(posedge sclk);
    #1;
    send(B_CT, B_KEY, B_PT);
    wait_valid("key_change", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
